dm_mem_stage_pipe: RTL and testbench
====================================

Name: dm_mem_stage_pipe

Overview:
- Parametrised successor of the Mem1 data-memory pipeline stage.
- Sits between Mem0 and Sw: executes store/load/select on an internal single-port synchronous data memory, then forwards operand plus token sideband to Sw.
- New over the previous generation:
  - widths and depth are parametrised;
  - byte-enable stores;
  - ready/valid handshake with backpressure from Sw, using a 3-entry output queue;
  - a per-entry load-data-valid flag.

Parameters:
- DW, 32, operand/data width in bits; multiple of 8.
- AW, 14, word-address width; memory depth is 2**AW words.
- TW, 35, packed sideband token width: pe_out, pe_num, f_mem_w, next_lr, next_node, gen, next_uni_opr.
- QD, 3, output queue depth; fixed minimum 3, allowed values 3..8.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid_i  in  1  Mem0 presents an operation
- in_ready_o  out  1  stage accepts the operation this cycle
- opr0_i  in  DW  store data / pass operand
- opr1_i  in  DW  alternate operand
- addr_i  in  AW  word address
- dopc_i  in  2  00 pass opr0, 01 store, 10 load, 11 pass opr1
- be_i  in  DW/8  byte enables for store
- tag_i  in  TW  sideband token
- out_valid_o  out  1  queue head valid
- out_ready_i  in  1  Sw consumes the head
- opr0_o  out  DW  selected operand
- data_o  out  DW  load data
- data_valid_o  out  1  head entry was a load
- tag_o  out  TW  sideband of head
- busy_o  out  1  stage S1 or queue non-empty

Behaviour:
- Handshake:
  - Accept when in_valid_i & in_ready_o.
  - Pop when out_valid_o & out_ready_i.
  - in_ready_o = (q_count + s1_valid) < QD. It is registered-state only, with no combinational path from out_ready_i.
- Stage S1 (capture on accept):
  - Capture dopc, opr0/opr1 selection, tag and addr into the S1 register.
  - The memory access happens at the same edge.
  - Store (01): for each byte b with be_i[b]=1, mem[addr_i][8b+7:8b] <= opr0_i[8b+7:8b]. be_i=0 makes the store a no-op.
  - Load (10): synchronous read; data is available in the S1 cycle.
  - Other opcodes do not access the memory. The memory has one port and at most one access per cycle, so there are no read/write hazards.
  - A load following a store to the same address in the next accepted cycle returns the newly written bytes.
- Queue push:
  - When s1_valid, push {opr_sel, rdata, dopc==10, tag} into the queue the cycle after accept.
  - Space is guaranteed by the in_ready_o rule.
  - opr_sel = opr1 if dopc==11, else opr0.
  - rdata is forced to 0 when dopc!=10.
- Queue: FIFO of depth QD.
  - Push and pop may occur in the same cycle; count is unchanged.
  - Pop on empty is impossible, because out_valid_o=0.
  - Ordering is strictly preserved.
- Latency:
  - Accept-to-out_valid_o is 2 cycles with an empty queue.
  - Throughput is 1 op/cycle while out_ready_i stays high.
- Backpressure: with out_ready_i held low, the stage accepts exactly QD ops (one may remain in S1 until a queue slot is free), then in_ready_o=0. Head outputs hold stable while stalled.
- Reset (synchronous, rst=1):
  - s1_valid=0, q_count=0, queue pointers=0.
  - out_valid_o=0, data_valid_o=0, opr0_o=0, data_o=0, tag_o=0, busy_o=0.
  - in_ready_o=1 on the first cycle after reset.
  - Memory contents are not reset.
  - Reset mid-operation discards S1 and queue contents. A store accepted at the same edge as rst=1 is not performed.
- Address: addr_i is a word address; there is no wrap logic, and the full 2**AW range is valid.

Decomposition:
- Package dm_pkg:
  - dopc encodings DOPC_PASS0/STORE/LOAD/PASS1;
  - default widths;
  - the tag field offsets, so Mem0/Sw pack and unpack identically.
- Sub-module dm_ram_sp: parametrised (DW, AW) single-port synchronous RAM with byte-enable write and registered read.
- The output queue is kept inline.

Test Plan:
- Store/load: store 0xDEADBEEF @0x0010 be=1111, then load @0x0010 → after 2 cycles data_o=0xDEADBEEF, data_valid_o=1, tag matches.
- Byte enables: store 0xFFFFFFFF be=1111, then 0x00000012 be=0001 @0x0004, then load → 0xFFFFFF12. A store with be=0000 leaves the word unchanged.
- Opcodes: dopc=11 with opr0=1, opr1=2 → opr0_o=2, data_valid_o=0, data_o=0. dopc=00 → opr0_o=1.
- Backpressure: out_ready_i=0 with continuous valid → exactly 3 accepts, then in_ready_o=0. Release → 3 pops in order, no loss or duplication. Random out_ready_i over 1000 ops matches a scoreboard.
- Throughput: out_ready_i=1 with 100 back-to-back ops → 100 outputs in 101 cycles, in_ready_o never low.
- Reset: rst=1 with 2 entries queued plus a store in flight → next cycle out_valid_o=0, in_ready_o=1; the in-flight store address retains its old value on reload.

Source files
------------

// File: rtl/dm_mem_stage_pipe_pkg.sv
// dm_mem_stage_pipe shared types: data opcodes, default widths, tag layout.
// Mem0 and Sw use tag_pack and the offsets so they pack and unpack identically.
package dm_pkg;

  typedef enum logic [1:0] {
    DOPC_PASS0 = 2'b00,
    DOPC_STORE = 2'b01,
    DOPC_LOAD  = 2'b10,
    DOPC_PASS1 = 2'b11
  } dopc_e;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 14;
  localparam int TW_DEF = 35;
  localparam int QD_DEF = 3;

  localparam int TAG_UNI_W      = 16;
  localparam int TAG_GEN_W      = 4;
  localparam int TAG_NODE_W     = 8;
  localparam int TAG_PE_NUM_W   = 4;

  localparam int TAG_UNI_OFF    = 0;
  localparam int TAG_GEN_OFF    = 16;
  localparam int TAG_NODE_OFF   = 20;
  localparam int TAG_LR_OFF     = 28;
  localparam int TAG_FMW_OFF    = 29;
  localparam int TAG_PE_NUM_OFF = 30;
  localparam int TAG_PE_OUT_OFF = 34;

  function automatic logic [TW_DEF-1:0] tag_pack(
    input logic                    pe_out,
    input logic [TAG_PE_NUM_W-1:0] pe_num,
    input logic                    f_mem_w,
    input logic                    next_lr,
    input logic [TAG_NODE_W-1:0]   next_node,
    input logic [TAG_GEN_W-1:0]    gen,
    input logic [TAG_UNI_W-1:0]    next_uni_opr
  );
    logic [TW_DEF-1:0] t;
    t = '0;
    t[TAG_PE_OUT_OFF] = pe_out;
    t[TAG_PE_NUM_OFF +: TAG_PE_NUM_W] = pe_num;
    t[TAG_FMW_OFF] = f_mem_w;
    t[TAG_LR_OFF] = next_lr;
    t[TAG_NODE_OFF +: TAG_NODE_W] = next_node;
    t[TAG_GEN_OFF +: TAG_GEN_W] = gen;
    t[TAG_UNI_OFF +: TAG_UNI_W] = next_uni_opr;
    return t;
  endfunction

endpackage

// File: rtl/dm_mem_stage_pipe_if.sv
// Mem0 -> stage -> Sw handshake bundle.
// master drives the operation side, slave is the stage itself.
interface dm_mem_stage_pipe_if
  import dm_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int TW = TW_DEF
);

  logic            in_valid_i;
  logic            in_ready_o;
  logic [DW-1:0]   opr0_i;
  logic [DW-1:0]   opr1_i;
  logic [AW-1:0]   addr_i;
  logic [1:0]      dopc_i;
  logic [DW/8-1:0] be_i;
  logic [TW-1:0]   tag_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [DW-1:0]   opr0_o;
  logic [DW-1:0]   data_o;
  logic            data_valid_o;
  logic [TW-1:0]   tag_o;
  logic            busy_o;

  modport master (
    output in_valid_i, opr0_i, opr1_i, addr_i,
    output dopc_i, be_i, tag_i, out_ready_i,
    input  in_ready_o, out_valid_o, opr0_o,
    input  data_o, data_valid_o, tag_o, busy_o
  );

  modport slave (
    input  in_valid_i, opr0_i, opr1_i, addr_i,
    input  dopc_i, be_i, tag_i, out_ready_i,
    output in_ready_o, out_valid_o, opr0_o,
    output data_o, data_valid_o, tag_o, busy_o
  );

endinterface

// File: rtl/dm_mem_stage_pipe_ram.sv
// Single-port synchronous RAM, byte-enable write, registered read.
// rdata holds its value on cycles without a read.
module dm_ram_sp
  import dm_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic            clk,
  input  logic            en,
  input  logic            we,
  input  logic [DW/8-1:0] be,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   wdata,
  output logic [DW-1:0]   rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < DW/8; b++) begin
          if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dm_mem_stage_pipe.sv
// Mem1 data-memory stage: S1 access register, RAM, QD-deep output queue.
// in_ready_o depends on registered occupancy only, never on out_ready_i.
module dm_mem_stage_pipe
  import dm_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int TW = TW_DEF,
  parameter int QD = QD_DEF
) (
  input logic clk,
  input logic rst,
  dm_mem_stage_pipe_if.slave bus
);

  localparam int PW = (QD > 1) ? $clog2(QD) : 1;
  localparam int CW = $clog2(QD + 1);
  localparam int SW = CW + 1;

  typedef struct packed {
    logic [DW-1:0] opr;
    logic [DW-1:0] data;
    logic          load;
    logic [TW-1:0] tag;
  } ent_t;

  logic          accept;
  logic          pop;
  logic          push;
  logic          is_store;
  logic          is_load;
  logic          mem_en;
  logic          s1_valid;
  logic          s1_load;
  logic [DW-1:0] s1_opr;
  logic [TW-1:0] s1_tag;
  logic [DW-1:0] rdata;
  ent_t          q [QD];
  ent_t          head;
  ent_t          ent;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [SW-1:0] occ;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QD - 1)) ? '0 : p + PW'(1);
  endfunction

  assign accept   = bus.in_valid_i & bus.in_ready_o;
  assign pop      = bus.out_valid_o & bus.out_ready_i;
  assign push     = s1_valid;
  assign is_store = bus.dopc_i == DOPC_STORE;
  assign is_load  = bus.dopc_i == DOPC_LOAD;
  // an op accepted on a reset edge must not touch memory
  assign mem_en   = accept & ~rst & (is_store | is_load);

  dm_ram_sp #(
    .DW(DW),
    .AW(AW)
  ) u_ram (
    .clk   (clk),
    .en    (mem_en),
    .we    (is_store),
    .be    (bus.be_i),
    .addr  (bus.addr_i),
    .wdata (bus.opr0_i),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_opr  <= (bus.dopc_i == DOPC_PASS1) ? bus.opr1_i
                                            : bus.opr0_i;
      s1_load <= is_load;
      s1_tag  <= bus.tag_i;
    end
  end

  always_comb begin
    ent      = '0;
    ent.opr  = s1_opr;
    ent.data = s1_load ? rdata : '0;
    ent.load = s1_load;
    ent.tag  = s1_tag;
  end

  always_ff @(posedge clk) begin
    if (push) q[wr_ptr] <= ent;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign occ  = SW'(count) + SW'(s1_valid);
  assign head = q[rd_ptr];

  assign bus.in_ready_o   = occ < SW'(QD);
  assign bus.out_valid_o  = count != '0;
  assign bus.opr0_o       = bus.out_valid_o ? head.opr : '0;
  assign bus.data_o       = bus.out_valid_o ? head.data : '0;
  assign bus.data_valid_o = bus.out_valid_o & head.load;
  assign bus.tag_o        = bus.out_valid_o ? head.tag : '0;
  assign bus.busy_o       = s1_valid | bus.out_valid_o;

endmodule

// File: tb/tb_dm_mem_stage_pipe.sv
// Bench for dm_mem_stage_pipe: directed vectors plus a queue/array model
// compared on every negedge.
module tb_dm_mem_stage_pipe;
  import dm_pkg::*;

  localparam int DW = 32;
  localparam int AW = 14;
  localparam int TW = 35;
  localparam int QD = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dm_mem_stage_pipe_if #(.DW(DW), .AW(AW), .TW(TW)) bus ();

  dm_mem_stage_pipe #(
    .DW(DW), .AW(AW), .TW(TW), .QD(QD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] opr;
    logic [31:0] data;
    logic        dv;
    logic [34:0] tag;
    int          cyc;
    bit          known;
  } exp_t;

  typedef struct {
    logic [31:0] opr;
    logic [31:0] data;
    logic        dv;
    logic [34:0] tag;
  } out_t;

  exp_t        exp_q [$];
  out_t        popped [$];
  logic [31:0] mem_m [int];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int n_pop = 0;
  int last_pop_cyc = 0;
  int mark_cyc = 0;
  bit mark_pending = 1'b0;
  bit rand_mode = 1'b0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // reference model: accepted-not-popped list in order, word-array memory
  always @(negedge clk) begin : mon
    exp_t e;
    out_t o;
    logic ev;
    logic [31:0] w;
    int a;
    cyc++;
    if (rst) begin
      exp_q.delete();
    end else begin
      chk("in_ready", bus.in_ready_o, exp_q.size() < QD);
      chk("busy", bus.busy_o, exp_q.size() > 0);
      ev = (exp_q.size() > 0) && (cyc >= exp_q[0].cyc + 2);
      chk("out_valid", bus.out_valid_o, ev);
      if (bus.out_valid_o && exp_q.size() > 0) begin
        chk("opr0_o", bus.opr0_o, exp_q[0].opr);
        chk("data_valid", bus.data_valid_o, exp_q[0].dv);
        chk("tag_o", bus.tag_o, exp_q[0].tag);
        if (exp_q[0].known) chk("data_o", bus.data_o, exp_q[0].data);
      end
      if (bus.out_valid_o && bus.out_ready_i) begin
        o.opr = bus.opr0_o;
        o.data = bus.data_o;
        o.dv = bus.data_valid_o;
        o.tag = bus.tag_o;
        popped.push_back(o);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        n_pop++;
        last_pop_cyc = cyc;
      end
      if (bus.in_valid_i && bus.in_ready_o) begin
        a = int'(bus.addr_i);
        e.opr = (bus.dopc_i == 2'b11) ? bus.opr1_i : bus.opr0_i;
        e.dv = bus.dopc_i == 2'b10;
        e.data = '0;
        e.known = 1'b1;
        e.tag = bus.tag_i;
        e.cyc = cyc;
        if (e.dv) begin
          if (mem_m.exists(a)) e.data = mem_m[a];
          else e.known = 1'b0;
        end
        if (bus.dopc_i == 2'b01) begin
          w = mem_m.exists(a) ? mem_m[a] : 32'h0;
          for (int b = 0; b < 4; b++)
            if (bus.be_i[b]) w[8*b +: 8] = bus.opr0_i[8*b +: 8];
          mem_m[a] = w;
        end
        exp_q.push_back(e);
        if (mark_pending) begin
          mark_cyc = cyc;
          mark_pending = 1'b0;
        end
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (rand_mode) bus.out_ready_i = 1'($urandom % 2);
  end

  task automatic send(input logic [1:0] d, input int a,
                      input logic [31:0] o0, input logic [31:0] o1,
                      input logic [3:0] be, input logic [34:0] t,
                      output int stalls);
    bit ok;
    stalls = 0;
    bus.dopc_i = d;
    bus.addr_i = AW'(a);
    bus.opr0_i = o0;
    bus.opr1_i = o1;
    bus.be_i = be;
    bus.tag_i = t;
    bus.in_valid_i = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      ok = bus.in_ready_o;
      @(posedge clk);
      #1;
      if (ok) return;
      stalls++;
    end
    vectors++;
    miscompares++;
    $display("FAIL send_timeout: got in_ready 0 expected 1 within 300");
    bus.in_valid_i = 1'b0;
  endtask

  task automatic op(input logic [1:0] d, input int a,
                    input logic [31:0] o0, input logic [31:0] o1,
                    input logic [3:0] be, input logic [34:0] t);
    int s;
    send(d, a, o0, o1, be, t, s);
  endtask

  task automatic drain();
    bus.in_valid_i = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (!bus.busy_o) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    vectors++;
    miscompares++;
    $display("FAIL drain_timeout: got busy 1 expected 0 within 400");
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int p;
    int acc;
    int st;
    int lows;
    int n0;
    bit r;
    logic [34:0] tg;

    bus.in_valid_i = 1'b0;
    bus.out_ready_i = 1'b1;
    bus.opr0_i = '0;
    bus.opr1_i = '0;
    bus.addr_i = '0;
    bus.dopc_i = 2'b00;
    bus.be_i = '0;
    bus.tag_i = '0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid_o, 1'b0);
    chk("rst_in_ready", bus.in_ready_o, 1'b1);
    chk("rst_busy", bus.busy_o, 1'b0);
    chk("rst_opr0", bus.opr0_o, 32'h0);
    chk("rst_data", bus.data_o, 32'h0);
    chk("rst_dv", bus.data_valid_o, 1'b0);
    chk("rst_tag", bus.tag_o, 35'h0);
    @(posedge clk);
    #1;

    // store then load
    tg = tag_pack(1'b1, 4'h3, 1'b1, 1'b0, 8'h5A, 4'h2, 16'hBEEF);
    p = popped.size();
    op(2'b01, 'h10, 32'hDEADBEEF, 32'h0, 4'hF, 35'h0);
    op(2'b10, 'h10, 32'h0, 32'h0, 4'h0, tg);
    drain();
    chk("st_pass_opr", popped[p].opr, 32'hDEADBEEF);
    chk("st_dv", popped[p].dv, 1'b0);
    chk("st_data", popped[p].data, 32'h0);
    chk("ld_data", popped[p+1].data, 32'hDEADBEEF);
    chk("ld_dv", popped[p+1].dv, 1'b1);
    chk("ld_tag", popped[p+1].tag, 35'h4_E5A2_BEEF);

    // byte enables
    p = popped.size();
    op(2'b01, 4, 32'hFFFFFFFF, 32'h0, 4'hF, 35'h0);
    op(2'b01, 4, 32'h00000012, 32'h0, 4'h1, 35'h0);
    op(2'b10, 4, 32'h0, 32'h0, 4'h0, 35'h1);
    op(2'b01, 4, 32'h00000000, 32'h0, 4'h0, 35'h0);
    op(2'b10, 4, 32'h0, 32'h0, 4'h0, 35'h2);
    drain();
    chk("be_merge", popped[p+2].data, 32'hFFFFFF12);
    chk("be_zero", popped[p+4].data, 32'hFFFFFF12);

    // pass opcodes
    p = popped.size();
    op(2'b11, 0, 32'h1, 32'h2, 4'h0, 35'h7);
    op(2'b00, 0, 32'h1, 32'h2, 4'h0, 35'h8);
    drain();
    chk("pass1_opr", popped[p].opr, 32'h2);
    chk("pass1_dv", popped[p].dv, 1'b0);
    chk("pass1_data", popped[p].data, 32'h0);
    chk("pass0_opr", popped[p+1].opr, 32'h1);

    // backpressure
    bus.out_ready_i = 1'b0;
    p = popped.size();
    acc = 0;
    bus.dopc_i = 2'b11;
    bus.opr0_i = 32'h0;
    bus.opr1_i = 32'hA1;
    bus.tag_i = 35'h0;
    bus.in_valid_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      r = bus.in_ready_o;
      @(posedge clk);
      #1;
      if (r) begin
        acc++;
        bus.opr1_i = 32'hA1 + 32'(acc);
        bus.tag_i = 35'(acc);
      end
    end
    @(negedge clk);
    chk("bp_in_ready", bus.in_ready_o, 1'b0);
    @(posedge clk);
    #1;
    bus.in_valid_i = 1'b0;
    bus.out_ready_i = 1'b1;
    drain();
    chk("bp_accepts", 64'(acc), 64'd3);
    chk("bp_pops", 64'(popped.size() - p), 64'd3);
    chk("bp_ord0", popped[p].opr, 32'hA1);
    chk("bp_ord1", popped[p+1].opr, 32'hA2);
    chk("bp_ord2", popped[p+2].opr, 32'hA3);

    // throughput
    n0 = n_pop;
    lows = 0;
    mark_pending = 1'b1;
    for (int i = 0; i < 100; i++) begin
      send(2'b00, i, 32'(i), 32'h0, 4'h0, 35'(i), st);
      lows += st;
    end
    drain();
    chk("tp_stalls", 64'(lows), 64'd0);
    chk("tp_pops", 64'(n_pop - n0), 64'd100);
    chk("tp_cycles", 64'(last_pop_cyc - mark_cyc), 64'd101);

    // reset mid-operation
    op(2'b01, 'h20, 32'h11112222, 32'h0, 4'hF, 35'h0);
    drain();
    bus.out_ready_i = 1'b0;
    op(2'b00, 0, 32'h5, 32'h0, 4'h0, 35'h1);
    op(2'b00, 0, 32'h6, 32'h0, 4'h0, 35'h2);
    bus.dopc_i = 2'b01;
    bus.addr_i = AW'('h20);
    bus.opr0_i = 32'h99999999;
    bus.be_i = 4'hF;
    bus.in_valid_i = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid_i = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", bus.out_valid_o, 1'b0);
    chk("mid_rst_in_ready", bus.in_ready_o, 1'b1);
    chk("mid_rst_busy", bus.busy_o, 1'b0);
    @(posedge clk);
    #1;
    bus.out_ready_i = 1'b1;
    p = popped.size();
    op(2'b10, 'h20, 32'h0, 32'h0, 4'h0, 35'h3);
    drain();
    chk("mid_rst_keep", popped[p].data, 32'h11112222);

    // random backpressure against the model
    for (int a = 0; a < 16; a++)
      op(2'b01, 'h100 + a, $urandom, 32'h0, 4'hF, 35'h0);
    drain();
    n0 = n_pop;
    rand_mode = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom % 4 == 0) begin
        bus.in_valid_i = 1'b0;
        @(posedge clk);
        #1;
      end
      op(2'($urandom % 4), 'h100 + int'($urandom % 16), $urandom,
         $urandom, 4'($urandom % 16), {3'b0, 32'($urandom)});
    end
    rand_mode = 1'b0;
    bus.out_ready_i = 1'b1;
    drain();
    chk("rand_pops", 64'(n_pop - n0), 64'd1000);
    chk("rand_model_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
